// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-detecting interrupt controller with per-source pending
// bits, a software mask, fixed lowest-index-wins priority and a single
// in-flight request/take/ack handshake towards the cpu.
module intr_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             intr_en,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             take,
    input  logic             ack,
    output logic             intr,
    output logic [ID_W-1:0]  intr_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] lost,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [N_SRC-1:0] src_q_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] lost_r;
    logic [1:0]       state_r;
    logic [ID_W-1:0]  intr_id_r;
    logic             intr_r;
    logic             busy_r;

    logic [N_SRC-1:0] event_s;
    logic [N_SRC-1:0] eligible_s;
    logic [N_SRC-1:0] clr_s;
    logic             take_hit_s;
    logic             any_s;
    logic [ID_W-1:0]  win_id_s;
    logic [1:0]       state_nxt_s;
    logic [ID_W-1:0]  id_nxt_s;

    // A rising edge is one event; a held level produces nothing further.
    assign event_s    = src_irq & ~src_q_r;
    assign eligible_s = pending_r & mask_r;
    assign any_s      = |eligible_s;
    assign take_hit_s = (state_r == ST_REQ) && take;

    // Decode which pending bit the accepted offer retires this cycle.
    always_comb begin
        clr_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if (take_hit_s && (intr_id_r == ID_W'(i))) begin
                clr_s[i] = 1'b1;
            end else begin
                clr_s[i] = 1'b0;
            end
        end
    end

    // Fixed priority: scan from the top so the lowest eligible index wins.
    always_comb begin
        win_id_s = {ID_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                win_id_s = ID_W'(i);
            end else begin
                win_id_s = win_id_s;
            end
        end
    end

    // Handshake sequencing: offer, then in-service until ack; no nesting.
    always_comb begin
        state_nxt_s = state_r;
        id_nxt_s    = intr_id_r;
        case (state_r)
            ST_IDLE: begin
                if (intr_en && any_s) begin
                    state_nxt_s = ST_REQ;
                    id_nxt_s    = win_id_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // take beats a simultaneous withdrawal; no preemption here.
                if (take) begin
                    state_nxt_s = ST_SERVICE;
                end else if (!intr_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                id_nxt_s    = {ID_W{1'b0}};
            end
        endcase
    end

    // Source sampling, pending/lost bookkeeping and the mask register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q_r   <= {N_SRC{1'b0}};
            pending_r <= {N_SRC{1'b0}};
            lost_r    <= {N_SRC{1'b0}};
            mask_r    <= {N_SRC{1'b1}};
        end else begin
            src_q_r   <= src_irq;
            // A new event on a bit being retired re-arms it and is not lost.
            pending_r <= (pending_r & ~clr_s) | event_s;
            lost_r    <= lost_r | (event_s & pending_r & ~clr_s);
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // FSM state and registered cpu-facing outputs derived from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            intr_id_r <= {ID_W{1'b0}};
            intr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            intr_id_r <= id_nxt_s;
            intr_r    <= (state_nxt_s == ST_REQ);
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign intr    = intr_r;
    assign intr_id = intr_id_r;
    assign pending = pending_r;
    assign mask    = mask_r;
    assign lost    = lost_r;
    assign busy    = busy_r;

endmodule
